// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types and constants for the AXI4-Lite initiator
package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator with optional watchdog
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    output logic [2:0]            axi_arprot,
    input  logic                  axi_arready,
    input  logic [31:0]           axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    output logic [2:0]            axi_awprot,
    input  logic                  axi_awready,
    output logic [31:0]           axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready
);

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_n;
    logic                    aw_done;
    logic                    w_done;
    logic [15:0]             wd_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [31:0]             rdata_q;
    logic                    err_q;
    logic                    timeout_hit;
    logic                    accept;
    logic                    rd_fin;
    logic                    wr_fin;
    logic                    abort;

    assign timeout_hit = TO_EN && (wd_cnt >= TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        rd_fin      = 1'b0;
        wr_fin      = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = req_we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (axi_arready) begin
                    state_n = RD_DATA;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            RD_DATA: begin
                if (axi_rvalid) begin
                    rd_fin  = 1'b1;
                    state_n = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            WR_REQ: begin
                // AW and W may complete in either order or together
                if ((aw_done || axi_awready) && (w_done || axi_wready)) begin
                    state_n = WR_RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    wr_fin  = 1'b1;
                    state_n = DONE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        req_ready   = (state == IDLE);
        axi_arvalid = (state == RD_ADDR);
        axi_rready  = (state == RD_DATA);
        axi_awvalid = (state == WR_REQ) && !aw_done;
        axi_wvalid  = (state == WR_REQ) && !w_done;
        axi_bready  = (state == WR_RESP);
        resp_valid  = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wd_cnt  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                wd_cnt  <= '0;
            end else if (state != IDLE && state != DONE && wd_cnt != 16'hFFFF) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (state == WR_REQ && axi_awready) begin
                aw_done <= 1'b1;
            end
            if (state == WR_REQ && axi_wready) begin
                w_done <= 1'b1;
            end
            if (rd_fin) begin
                rdata_q <= axi_rdata;
                err_q   <= resp_is_err(axi_rresp);
            end
            if (wr_fin) begin
                rdata_q <= '0;
                err_q   <= resp_is_err(axi_bresp);
            end
            if (abort) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign axi_araddr = addr_q;
    assign axi_awaddr = addr_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign axi_arprot = PROT_DEFAULT;
    assign axi_awprot = PROT_DEFAULT;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
